// File: rtl/operand_stack.sv
// operand_stack: register-array LIFO holding ALU operands between memory and the datapath.
// Latency: push/pop/replace take effect at the rising edge; tos/nos/count reflect it right after (zero-cycle read).
// Backpressure: none. An illegal push (full) or pop (empty) is dropped with no state change and flagged.
//
// Ports:
//   clk, rst     rising-edge clock; asynchronous active-high reset
//   push, pop    operation request sampled at the rising edge (both = replace top)
//   d_in         data written by push / replace
//   clr_err      synchronous clear of the sticky error flags
//   tos, nos     top and next-on-stack entries, forced to 0 when not valid
//   count        number of valid entries 0..DEPTH; empty/full decoded from it
//   overflow     sticky: push attempted while full
//   underflow    sticky: pop (or replace) attempted while empty
//
// Build option: define OPERAND_STACK_ERR_EN to build the sticky error flags.
// Without it overflow/underflow are tied low and clr_err is ignored; illegal
// operations are still dropped.

module operand_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] d_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [5:0]       count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  // Index width for the storage array; DEPTH=2 still needs one bit.
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [5:0] DEPTH_C = 6'(DEPTH);

  // Reject illegal depths at elaboration: count is only 6 bits wide.
  if (DEPTH < 2 || DEPTH > 32) begin : g_bad_depth
    $error("operand_stack: DEPTH must be in 2..32");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [5:0]       count_q;
  logic [5:0]       count_d;

  // Decoded operation for this edge.
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic             ovf_evt;
  logic             unf_evt;

  // Read pointers. When count is 0 or 1 these wrap to garbage indices, but the
  // output mux below never lets those entries through.
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    nos_idx;

  assign top_idx = AW'(count_q - 6'd1);
  assign nos_idx = AW'(count_q - 6'd2);

  // ---------------------------------------------------------------------------
  // Status and read path
  // ---------------------------------------------------------------------------
  assign count = count_q;
  assign empty = (count_q == 6'd0);
  assign full  = (count_q == DEPTH_C);

  always_comb begin
    tos = '0;
    nos = '0;
    if (count_q >= 6'd1) tos = mem_q[top_idx];
    if (count_q >= 6'd2) nos = mem_q[nos_idx];
  end

  // ---------------------------------------------------------------------------
  // Next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = '0;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;

    unique case ({push, pop})
      2'b10: begin
        // Push: write the first free slot, which is exactly index count.
        if (full) begin
          ovf_evt = 1'b1;
        end else begin
          wr_en   = 1'b1;
          wr_idx  = AW'(count_q);
          count_d = count_q + 6'd1;
        end
      end
      2'b01: begin
        // Pop: the consumer has already taken tos this cycle, so only the
        // pointer moves; the stale entry stays in the array unobserved.
        if (empty) begin
          unf_evt = 1'b1;
        end else begin
          count_d = count_q - 6'd1;
        end
      end
      2'b11: begin
        // Replace: overwrite the top in place. Legal when full because the
        // pointer does not move.
        if (empty) begin
          unf_evt = 1'b1;
        end else begin
          wr_en  = 1'b1;
          wr_idx = top_idx;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_idx] = d_in;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 6'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage is not reset; entries above count are masked on the read side.
  // Writes are suppressed while rst is high so a reset cycle never lands data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= mem_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
`ifdef OPERAND_STACK_ERR_EN
  logic overflow_q;
  logic overflow_d;
  logic underflow_q;
  logic underflow_d;

  // A new error on the same edge as clr_err wins, so nothing is lost.
  always_comb begin
    overflow_d  = (overflow_q  & ~clr_err) | ovf_evt;
    underflow_d = (underflow_q & ~clr_err) | unf_evt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  logic unused_err;

  assign unused_err = ^{clr_err, ovf_evt, unf_evt};
  assign overflow   = 1'b0;
  assign underflow  = 1'b0;
`endif

endmodule
